// File: rtl/mbscore_operand_stage_pkg.sv
// Shared encodings and default widths for the operand stage.
// The optional counter is enabled by MBSCORE_OPSTAGE_PERF_EN.
package mbscore_operand_stage_pkg;

  localparam int unsigned ALU_SEL_WIDTH = 2;

  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_REG   = 2'd0;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_IMM   = 2'd1;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_SHAMT = 2'd2;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_ZERO  = 2'd3;

  localparam logic [1:0] IMM_MODE_ZERO  = 2'd0;
  localparam logic [1:0] IMM_MODE_SIGN  = 2'd1;
  localparam logic [1:0] IMM_MODE_UPPER = 2'd2;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;

endpackage

// File: rtl/mbscore_fwd_select.sv
// Forwarding priority match and data mux for one operand; the lowest
// matching source index wins and register index 0 is never forwarded.
module mbscore_fwd_select #(
  parameter int unsigned NUM_FWD        = 3,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                              en_i,
  input  logic [REG_ADDR_WIDTH-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0]             reg_data_i,
  input  logic [NUM_FWD-1:0]                fwd_valid_i,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_addr_i,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data_i,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic                              hit_o
);

  always_comb begin
    data_o = reg_data_i;
    hit_o  = 1'b0;
    if (en_i && (addr_i != '0)) begin
      // Walk from oldest to youngest so the youngest match overwrites last.
      for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
        if (fwd_valid_i[i] && (fwd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr_i)) begin
          data_o = fwd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          hit_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mbscore_operand_stage.sv
// Operand select, bypass and valid/ready output register ahead of the ALU.
// Define MBSCORE_OPSTAGE_PERF_EN to add the fwd_count forwarded-operand counter.
module mbscore_operand_stage
  import mbscore_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned IMM_WIDTH      = 16,
  parameter int unsigned NUM_FWD        = 3,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [REG_ADDR_WIDTH-1:0]         rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0]         rt_addr,
  input  logic [DATA_WIDTH-1:0]             rs_data,
  input  logic [DATA_WIDTH-1:0]             rt_data,
  input  logic [IMM_WIDTH-1:0]              imm,
  input  logic [1:0]                        imm_mode,
  input  logic [4:0]                        shamt,
  input  logic [ALU_SEL_WIDTH-1:0]          alu_sel_a,
  input  logic [ALU_SEL_WIDTH-1:0]          alu_sel_b,
  input  logic [NUM_FWD-1:0]                fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             alu_in_a,
  output logic [DATA_WIDTH-1:0]             alu_in_b,
  output logic [1:0]                        fwd_hit
`ifdef MBSCORE_OPSTAGE_PERF_EN
  ,
  output logic [31:0]                       fwd_count
`endif
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]            hit_q, hit_d;

  logic                  accept, load;
  logic [DATA_WIDTH-1:0] imm_ext, shamt_ext;
  logic [DATA_WIDTH-1:0] reg_a, reg_b;
  logic                  hit_a, hit_b;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // Flush cancels a same-cycle accept.
  assign load     = accept && !flush;

  always_comb begin
    imm_ext = DATA_WIDTH'(imm);
    case (imm_mode)
      IMM_MODE_SIGN:  imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
      IMM_MODE_UPPER: imm_ext = {imm, {(DATA_WIDTH-IMM_WIDTH){1'b0}}};
      default:        imm_ext = DATA_WIDTH'(imm);
    endcase
  end

  assign shamt_ext = DATA_WIDTH'(shamt);

  mbscore_fwd_select #(
    .NUM_FWD       (NUM_FWD),
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_a (
    .en_i       (alu_sel_a == ALU_SEL_REG),
    .addr_i     (rs_addr),
    .reg_data_i (rs_data),
    .fwd_valid_i(fwd_valid),
    .fwd_addr_i (fwd_addr),
    .fwd_data_i (fwd_data),
    .data_o     (reg_a),
    .hit_o      (hit_a)
  );

  mbscore_fwd_select #(
    .NUM_FWD       (NUM_FWD),
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_b (
    .en_i       (alu_sel_b == ALU_SEL_REG),
    .addr_i     (rt_addr),
    .reg_data_i (rt_data),
    .fwd_valid_i(fwd_valid),
    .fwd_addr_i (fwd_addr),
    .fwd_data_i (fwd_data),
    .data_o     (reg_b),
    .hit_o      (hit_b)
  );

  always_comb begin
    valid_d = valid_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    hit_d   = hit_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      unique case (alu_sel_a)
        ALU_SEL_REG:   alu_a_d = reg_a;
        ALU_SEL_IMM:   alu_a_d = imm_ext;
        ALU_SEL_SHAMT: alu_a_d = shamt_ext;
        ALU_SEL_ZERO:  alu_a_d = '0;
      endcase
      unique case (alu_sel_b)
        ALU_SEL_REG:   alu_b_d = reg_b;
        ALU_SEL_IMM:   alu_b_d = imm_ext;
        ALU_SEL_SHAMT: alu_b_d = shamt_ext;
        ALU_SEL_ZERO:  alu_b_d = '0;
      endcase
      hit_d = {hit_b, hit_a};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      hit_q   <= '0;
    end else begin
      valid_q <= valid_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      hit_q   <= hit_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_in_a  = alu_a_q;
  assign alu_in_b  = alu_b_q;
  assign fwd_hit   = hit_q;

`ifdef MBSCORE_OPSTAGE_PERF_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = count_q + 32'(hit_a) + 32'(hit_b);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fwd_count = count_q;
`endif

endmodule
